// File: rtl/pcie_lane_os_gen.sv
// rtl/pcie_lane_os_gen.sv - per-lane PCIe Gen1/2 ordered-set transmitter (TS1/TS2/EIOS/FTS/SKP)
// Emits one registered symbol per clock with K-flag; inserts SKP ordered sets on an interval timer.
module pcie_lane_os_gen #(
  parameter int SKP_INTERVAL = 1180
) (
  input  logic       Clk,
  input  logic       notReset,
  input  logic       OsStart,
  input  logic [2:0] OsType,
  input  logic [7:0] OsCount,
  input  logic [7:0] LinkNum,
  input  logic [7:0] LaneNum,
  input  logic [7:0] NFts,
  input  logic [7:0] DataRate,
  input  logic [7:0] LinkCtrl,
  output logic       OsBusy,
  output logic       OsDone,
  output logic [7:0] TxByte,
  output logic       TxControl,
  output logic       TxOsStart,
  output logic       SkpPending
);

  localparam int TW = $clog2(SKP_INTERVAL + 1);
  localparam logic [TW-1:0] TMAX = TW'(SKP_INTERVAL);

  localparam logic [2:0] T_TS1  = 3'd0;
  localparam logic [2:0] T_TS2  = 3'd1;
  localparam logic [2:0] T_EIOS = 3'd2;
  localparam logic [2:0] T_FTS  = 3'd3;
  localparam logic [2:0] T_SKP  = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_SKPINS, ST_TAIL} state_t;

  // Registers describe the symbol currently on TxByte: its state, index and set count.
  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      left_q, left_d;
  logic [2:0]      type_q, type_d;
  logic [7:0]      link_q, link_d, lane_q, lane_d, nfts_q, nfts_d;
  logic [7:0]      rate_q, rate_d, ctrl_q, ctrl_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            eidle_q, eidle_d;
  logic [7:0]      byte_q, byte_d;
  logic            k_q, k_d, os_q, os_d, done_q, done_d;

  logic            accept, cur_ts, sym_ts, sym_last, skp_last, eios_last;
  logic [3:0]      last_idx;
  logic [2:0]      sym_type;

  always_ff @(posedge Clk) begin
    if (!notReset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      left_q  <= '0;
      type_q  <= '0;
      link_q  <= '0;
      lane_q  <= '0;
      nfts_q  <= '0;
      rate_q  <= '0;
      ctrl_q  <= '0;
      timer_q <= '0;
      eidle_q <= 1'b0;
      byte_q  <= '0;
      k_q     <= 1'b0;
      os_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      left_q  <= left_d;
      type_q  <= type_d;
      link_q  <= link_d;
      lane_q  <= lane_d;
      nfts_q  <= nfts_d;
      rate_q  <= rate_d;
      ctrl_q  <= ctrl_d;
      timer_q <= timer_d;
      eidle_q <= eidle_d;
      byte_q  <= byte_d;
      k_q     <= k_d;
      os_q    <= os_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    left_d   = left_q;
    type_d   = type_q;
    link_d   = link_q;
    lane_d   = lane_q;
    nfts_d   = nfts_q;
    rate_d   = rate_q;
    ctrl_d   = ctrl_q;
    byte_d   = 8'h00;
    k_d      = 1'b0;
    os_d     = 1'b0;
    done_d   = 1'b0;
    accept   = (state_q == ST_IDLE) && OsStart && (OsType <= T_SKP);
    cur_ts   = (type_q == T_TS1) || (type_q == T_TS2);
    last_idx = (state_q == ST_SEND && cur_ts) ? 4'd15 : 4'd3;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          idx_d   = 4'd0;
          left_d  = (OsCount == 8'd0) ? 8'd1 : OsCount;
          type_d  = OsType;
          link_d  = LinkNum;
          lane_d  = LaneNum;
          nfts_d  = NFts;
          rate_d  = DataRate;
          ctrl_d  = LinkCtrl;
        end
      end
      ST_SEND: begin
        if (idx_q != last_idx) begin
          idx_d = idx_q + 4'd1;
        end else if (left_q > 8'd1) begin
          // Set boundary with more to send: the only place a pending SKP may go out.
          left_d  = left_q - 8'd1;
          idx_d   = 4'd0;
          state_d = SkpPending ? ST_SKPINS : ST_SEND;
        end else begin
          idx_d   = 4'd0;
          state_d = (type_q == T_FTS) ? ST_TAIL : ST_IDLE;
        end
      end
      ST_SKPINS: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd3) begin
          idx_d   = 4'd0;
          state_d = ST_SEND;
        end
      end
      default: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd3) begin
          idx_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end
    endcase

    sym_type = (state_d == ST_SKPINS || state_d == ST_TAIL) ? T_SKP : type_d;
    sym_ts   = (sym_type == T_TS1) || (sym_type == T_TS2);
    sym_last = (idx_d == (sym_ts ? 4'd15 : 4'd3));

    if (state_d != ST_IDLE) begin
      if (idx_d == 4'd0) begin
        byte_d = 8'hBC;
        k_d    = 1'b1;
      end else if (sym_ts) begin
        case (idx_d)
          4'd1: begin byte_d = link_d; k_d = (link_d == 8'hF7); end
          4'd2: begin byte_d = lane_d; k_d = (lane_d == 8'hF7); end
          4'd3: byte_d = nfts_d;
          4'd4: byte_d = rate_d;
          4'd5: byte_d = ctrl_d;
          default: byte_d = (sym_type == T_TS1) ? 8'h4A : 8'h45;
        endcase
      end else begin
        k_d = 1'b1;
        case (sym_type)
          T_EIOS:  byte_d = 8'h7C;
          T_FTS:   byte_d = 8'h3C;
          default: byte_d = 8'h1C;
        endcase
      end
    end

    os_d   = (state_d != ST_IDLE) && (idx_d == 4'd0);
    done_d = (state_d != ST_IDLE) && sym_last &&
             ((state_d == ST_TAIL) ||
              (state_d == ST_SEND && left_d == 8'd1 && type_d != T_FTS));

    // Electrical idle freezes the timer until a non-EIOS request is accepted.
    skp_last  = (state_d != ST_IDLE) && (sym_type == T_SKP) && sym_last;
    eios_last = (state_d == ST_SEND) && (type_d == T_EIOS) && sym_last;
    eidle_d   = eios_last || (eidle_q && !(accept && OsType != T_EIOS));
    if (skp_last || eidle_d)
      timer_d = '0;
    else if (timer_q == TMAX)
      timer_d = timer_q;
    else
      timer_d = timer_q + TW'(1);
  end

  assign OsBusy     = (state_q != ST_IDLE);
  assign OsDone     = done_q;
  assign TxByte     = byte_q;
  assign TxControl  = k_q;
  assign TxOsStart  = os_q;
  assign SkpPending = (timer_q == TMAX);

endmodule

// File: tb/tb_pcie_lane_os_gen.sv
// tb/tb_pcie_lane_os_gen.sv - self-checking bench for pcie_lane_os_gen
// Expected symbol streams come from a queue-based model of the ordered-set rules.
module tb_pcie_lane_os_gen;

  localparam int INTV = 20;

  logic       Clk = 1'b0;
  logic       notReset = 1'b0;
  logic       OsStart = 1'b0;
  logic [2:0] OsType = 3'd0;
  logic [7:0] OsCount = 8'd0;
  logic [7:0] LinkNum = 8'd0, LaneNum = 8'd0, NFts = 8'd0, DataRate = 8'd0, LinkCtrl = 8'd0;
  logic       OsBusy, OsDone, TxControl, TxOsStart, SkpPending;
  logic [7:0] TxByte;

  pcie_lane_os_gen #(.SKP_INTERVAL(INTV)) dut (
    .Clk(Clk), .notReset(notReset), .OsStart(OsStart), .OsType(OsType), .OsCount(OsCount),
    .LinkNum(LinkNum), .LaneNum(LaneNum), .NFts(NFts), .DataRate(DataRate), .LinkCtrl(LinkCtrl),
    .OsBusy(OsBusy), .OsDone(OsDone), .TxByte(TxByte), .TxControl(TxControl),
    .TxOsStart(TxOsStart), .SkpPending(SkpPending)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] b;
    logic       k, os, done, busy, pend;
  } sym_t;

  sym_t        exp_q[$];
  logic [12:0] obs_q[$];
  int          m_timer = 0;
  bit          m_eidle = 1'b0;
  logic [7:0]  r_f[5];
  int          total = 0;
  int          bad = 0;

  function automatic logic [12:0] pack(input sym_t s);
    return {s.b, s.k, s.os, s.done, s.busy, s.pend};
  endfunction

  // Timer value during the symbol cycle being modelled.
  function automatic void adv(input bit skp_end, input bit eios_end);
    if (m_eidle) m_timer = 0;
    else if (m_timer < INTV) m_timer++;
    if (skp_end || eios_end) m_timer = 0;
    if (eios_end) m_eidle = 1'b1;
  endfunction

  function automatic void emit(input logic [7:0] b, input logic k, input bit skp_end, input bit eios_end);
    sym_t s;
    adv(skp_end, eios_end);
    s.b = b; s.k = k; s.os = k && (b == 8'hBC); s.done = 1'b0; s.busy = 1'b1;
    s.pend = (m_timer == INTV);
    exp_q.push_back(s);
  endfunction

  function automatic void emit_idle();
    sym_t s;
    adv(1'b0, 1'b0);
    s.b = 8'h00; s.k = 1'b0; s.os = 1'b0; s.done = 1'b0; s.busy = 1'b0;
    s.pend = (m_timer == INTV);
    exp_q.push_back(s);
  endfunction

  function automatic void emit_set(input logic [2:0] t);
    logic [7:0] sym;
    emit(8'hBC, 1'b1, 1'b0, 1'b0);
    if (t <= 3'd1) begin
      emit(r_f[0], r_f[0] == 8'hF7, 1'b0, 1'b0);
      emit(r_f[1], r_f[1] == 8'hF7, 1'b0, 1'b0);
      for (int i = 2; i < 5; i++) emit(r_f[i], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) emit((t == 3'd0) ? 8'h4A : 8'h45, 1'b0, 1'b0, 1'b0);
    end else begin
      sym = (t == 3'd2) ? 8'h7C : (t == 3'd3) ? 8'h3C : 8'h1C;
      for (int i = 0; i < 3; i++) emit(sym, 1'b1, (t == 3'd4) && (i == 2), (t == 3'd2) && (i == 2));
    end
  endfunction

  function automatic void build(input logic [2:0] t, input logic [7:0] cnt);
    int   n;
    sym_t s;
    exp_q.delete();
    if (t != 3'd2) m_eidle = 1'b0;
    n = (cnt == 0) ? 1 : int'(cnt);
    for (int i = 0; i < n; i++) begin
      emit_set(t);
      if (i < n - 1 && exp_q[exp_q.size() - 1].pend) emit_set(3'd4);
    end
    if (t == 3'd3) emit_set(3'd4);
    s = exp_q.pop_back();
    s.done = 1'b1;
    exp_q.push_back(s);
    emit_idle();
  endfunction

  task automatic do_reset();
    notReset = 1'b0;
    OsStart = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    notReset = 1'b1;
    m_timer = 0;
    m_eidle = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] cnt, input logic [7:0] l, input logic [7:0] la,
                      input logic [7:0] nf, input logic [7:0] dr, input logic [7:0] lc);
    OsStart = 1'b1; OsType = t; OsCount = cnt;
    LinkNum = l; LaneNum = la; NFts = nf; DataRate = dr; LinkCtrl = lc;
    r_f[0] = l; r_f[1] = la; r_f[2] = nf; r_f[3] = dr; r_f[4] = lc;
    build(t, cnt);
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge Clk); #1;
      OsStart = 1'b0; OsType = 3'($urandom); OsCount = 8'($urandom);
      LinkNum = 8'($urandom); LaneNum = 8'($urandom); NFts = 8'($urandom);
      DataRate = 8'($urandom); LinkCtrl = 8'($urandom);
      obs_q.push_back({TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending});
    end
  endtask

  task automatic test_reset();
    notReset = 1'b0;
    @(posedge Clk); #1;
    total++;
    if ({TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got %h want 0000", {TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending});
    end
    do_reset();
    total++;
    if ({TxByte, OsBusy, SkpPending} !== 10'd0) begin
      bad++;
      $display("FAIL reset_release got %h want 000", {TxByte, OsBusy, SkpPending});
    end
  endtask

  task automatic test_ts1_pad();
    int n_os;
    do_reset();
    send(3'd0, 8'd2, 8'hF7, 8'h03, 8'h20, 8'h02, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL ts1 sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    total++;
    if (exp_q.size() != 33 || obs_q[1][12:4] !== 9'h1EF || obs_q[2][12:4] !== 9'h006 || obs_q[6][12:5] !== 8'h4A) begin
      bad++;
      $display("FAIL ts1_layout got %h %h %h want 1ef 006 4a", obs_q[1][12:4], obs_q[2][12:4], obs_q[6][12:5]);
    end
    n_os = 0;
    for (int i = 0; i < 33; i++) if (obs_q[i][3]) n_os++;
    total++;
    if (!obs_q[0][3] || !obs_q[16][3] || n_os != 2 || !obs_q[31][2] || obs_q[32][1]) begin
      bad++;
      $display("FAIL ts1_timing got os=%0d done31=%b busy32=%b want os=2 done31=1 busy32=0", n_os, obs_q[31][2], obs_q[32][1]);
    end
  endtask

  task automatic test_ts2_count0();
    int nb;
    do_reset();
    send(3'd1, 8'd0, 8'h01, 8'h00, 8'h10, 8'h02, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL ts2 sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    nb = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) nb++;
    total++;
    if (nb != 16 || obs_q[10][12:5] !== 8'h45 || !obs_q[15][2]) begin
      bad++;
      $display("FAIL ts2_busy got busy=%0d id=%h want busy=16 id=45", nb, obs_q[10][12:5]);
    end
  endtask

  task automatic test_fts();
    do_reset();
    send(3'd3, 8'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL fts sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    total++;
    if (obs_q.size() != 17 || obs_q[8][12:5] !== 8'hBC || obs_q[9][12:5] !== 8'h3C || obs_q[12][12:5] !== 8'hBC ||
        obs_q[15][12:5] !== 8'h1C || !obs_q[15][2] || obs_q[16][0]) begin
      bad++;
      $display("FAIL fts_tail got n=%0d s12=%h s15=%h done=%b pend=%b want 17 bc 1c 1 0",
               obs_q.size(), obs_q[12][12:5], obs_q[15][12:5], obs_q[15][2], obs_q[16][0]);
    end
  endtask

  task automatic test_skp_insert();
    int nb;
    do_reset();
    send(3'd0, 8'd4, 8'h05, 8'h01, 8'h08, 8'h02, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL skpins sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    nb = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) nb++;
    total++;
    if (nb != 68 || obs_q[16][12:5] !== 8'hBC || obs_q[17][12:5] !== 8'h05 || obs_q[32][12:5] !== 8'hBC ||
        obs_q[33][12:5] !== 8'h1C || obs_q[35][12:5] !== 8'h1C || obs_q[36][12:5] !== 8'hBC || !obs_q[67][2]) begin
      bad++;
      $display("FAIL skpins_layout got busy=%0d s33=%h s36=%h want 68 1c bc", nb, obs_q[33][12:5], obs_q[36][12:5]);
    end
  endtask

  task automatic test_eios_idle();
    do_reset();
    send(3'd2, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL eios sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    total++;
    if (obs_q[0][12:4] !== 9'h179 || obs_q[3][12:4] !== 9'h0F9 || !obs_q[3][2]) begin
      bad++;
      $display("FAIL eios_layout got %h %h want 179 0f9", obs_q[0][12:4], obs_q[3][12:4]);
    end
    repeat (100) begin @(posedge Clk); #1; adv(1'b0, 1'b0); end
    total++;
    if (SkpPending !== 1'b0 || OsBusy !== 1'b0) begin
      bad++;
      $display("FAIL eios_timer_hold got pend=%b busy=%b want 0 0", SkpPending, OsBusy);
    end
    OsStart = 1'b1; OsType = 3'd6;
    @(posedge Clk); #1;
    OsStart = 1'b0;
    adv(1'b0, 1'b0);
    repeat (2) begin
      total++;
      if (OsBusy !== 1'b0 || TxByte !== 8'h00 || OsDone !== 1'b0) begin
        bad++;
        $display("FAIL illegal_type got busy=%b byte=%h want 0 00", OsBusy, TxByte);
      end
      @(posedge Clk); #1; adv(1'b0, 1'b0);
    end
    send(3'd0, 8'd2, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL post_eios sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(3'd4, 8'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL b2b_skp sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    send(3'd0, 8'd3, 8'hF7, 8'hF7, 8'h11, 8'h02, 8'h01);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL b2b_ts1 sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
    total++;
    if (obs_q[0][12:4] !== 9'h179) begin
      bad++;
      $display("FAIL b2b_first got %h want 179", obs_q[0][12:4]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    OsStart = 1'b1; OsType = 3'd0; OsCount = 8'd2;
    LinkNum = 8'h01; LaneNum = 8'h02; NFts = 8'h03; DataRate = 8'h04; LinkCtrl = 8'h05;
    r_f[0] = 8'h01; r_f[1] = 8'h02; r_f[2] = 8'h03; r_f[3] = 8'h04; r_f[4] = 8'h05;
    build(3'd0, 8'd2);
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      OsStart = 1'b0;
      total++;
      if ({TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending} !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL midrst_pre sym%0d got %h want %h", i,
                 {TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending}, pack(exp_q[i]));
      end
    end
    notReset = 1'b0;
    @(posedge Clk); #1;
    total++;
    if ({TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending} !== 13'd0) begin
      bad++;
      $display("FAIL midrst_abort got %h want 0000", {TxByte, TxControl, TxOsStart, OsDone, OsBusy, SkpPending});
    end
    notReset = 1'b1;
    m_timer = 0;
    m_eidle = 1'b0;
    send(3'd0, 8'd1, 8'h09, 8'h00, 8'h40, 8'h02, 8'h00);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== pack(exp_q[i])) begin
        bad++;
        $display("FAIL midrst_restart sym%0d got %h want %h", i, obs_q[i], pack(exp_q[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] t;
    logic [7:0] l, la;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      t = 3'($urandom_range(0, 7));
      if (t > 3'd4) begin
        OsStart = 1'b1; OsType = t;
        @(posedge Clk); #1;
        OsStart = 1'b0;
        adv(1'b0, 1'b0);
        total++;
        if ({OsBusy, TxByte, SkpPending} !== {1'b0, 8'h00, m_timer == INTV}) begin
          bad++;
          $display("FAIL rnd_illegal r%0d got %h want %h", r, {OsBusy, TxByte, SkpPending}, {1'b0, 8'h00, m_timer == INTV});
        end
      end else begin
        l  = ($urandom_range(0, 2) == 0) ? 8'hF7 : 8'($urandom);
        la = ($urandom_range(0, 2) == 0) ? 8'hF7 : 8'($urandom);
        send(t, 8'($urandom_range(0, 4)), l, la, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < exp_q.size(); i++) begin
          total++;
          if (obs_q[i] !== pack(exp_q[i])) begin
            bad++;
            $display("FAIL rnd r%0d type%0d sym%0d got %h want %h", r, t, i, obs_q[i], pack(exp_q[i]));
          end
        end
      end
      repeat ($urandom_range(0, 25)) begin
        @(posedge Clk); #1;
        adv(1'b0, 1'b0);
        total++;
        if ({OsBusy, TxByte, SkpPending} !== {1'b0, 8'h00, m_timer == INTV}) begin
          bad++;
          $display("FAIL rnd_gap r%0d got %h want %h", r, {OsBusy, TxByte, SkpPending}, {1'b0, 8'h00, m_timer == INTV});
        end
      end
    end
  endtask

  initial begin
    @(posedge Clk); #1;
    test_reset();
    test_ts1_pad();
    test_ts2_count0();
    test_fts();
    test_skp_insert();
    test_eios_idle();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
